// File: rtl/cmp_array.sv
// ---------------------------------------------------------------------------
// cmp_array -- multi-lane registered magnitude comparator with valid/ready
// handshake and optional saturating statistics counters.
//
// Optional feature macro: CMP_ARRAY_STATS_EN
//   defined   -> eq_count/lt_count/gt_count ports and counters exist;
//                stats_clr clears them synchronously.
//   undefined -> no counter ports or logic; stats_clr is ignored.
//
// Parameters
//   WIDTH      operand width per lane (2..64), default soc_pkg::DATA_WIDTH
//   CHANNELS   number of compare lanes (1..16)
//   CNT_WIDTH  width of each statistics counter
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake; in_ready = !out_valid || out_ready
//   signed_mode           1: two's complement compare, 0: unsigned
//   a, b                  packed operands, lane i at [i*WIDTH +: WIDTH]
//   out_valid / out_ready result handshake
//   equal, less, greater  per-lane a==b, a<b, a>b (registered)
//   all_equal             AND of all equal bits (registered)
//   stats_clr             synchronous counter clear
//   eq_count/lt_count/gt_count  saturating popcount accumulators (macro only)
// ---------------------------------------------------------------------------
package soc_pkg;
  localparam int unsigned DATA_WIDTH = 32;
endpackage

module cmp_array
  import soc_pkg::*;
#(
  parameter int unsigned WIDTH     = DATA_WIDTH,
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         signed_mode,
  input  logic [CHANNELS*WIDTH-1:0]    a,
  input  logic [CHANNELS*WIDTH-1:0]    b,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CHANNELS-1:0]          equal,
  output logic [CHANNELS-1:0]          less,
  output logic [CHANNELS-1:0]          greater,
  input  logic                         stats_clr,
`ifdef CMP_ARRAY_STATS_EN
  output logic [CNT_WIDTH-1:0]         eq_count,
  output logic [CNT_WIDTH-1:0]         lt_count,
  output logic [CNT_WIDTH-1:0]         gt_count,
`endif
  output logic                         all_equal
);

  logic                transfer;
  logic [WIDTH-1:0]    bias;
  logic [CHANNELS-1:0] eq_d;
  logic [CHANNELS-1:0] lt_d;
  logic [CHANNELS-1:0] gt_d;

  assign in_ready = !out_valid || out_ready;
  assign transfer = in_valid && in_ready;

  // Flipping the MSB of both operands maps two's complement ordering onto
  // unsigned ordering, so one unsigned comparator serves both modes.
  assign bias = {signed_mode, {(WIDTH-1){1'b0}}};

  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    logic [WIDTH-1:0] ka;
    logic [WIDTH-1:0] kb;
    assign ka      = a[g*WIDTH +: WIDTH] ^ bias;
    assign kb      = b[g*WIDTH +: WIDTH] ^ bias;
    assign eq_d[g] = (ka == kb);
    assign lt_d[g] = (ka <  kb);
    assign gt_d[g] = (ka >  kb);
  end

  // Result registers: load on transfer, hold otherwise; out_valid drops only
  // when the consumer takes the result and nothing new arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      equal     <= '0;
      less      <= '0;
      greater   <= '0;
      all_equal <= 1'b0;
    end else if (transfer) begin
      out_valid <= 1'b1;
      equal     <= eq_d;
      less      <= lt_d;
      greater   <= gt_d;
      all_equal <= &eq_d;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef CMP_ARRAY_STATS_EN
  localparam int unsigned PCW = $clog2(CHANNELS + 1);
  localparam int unsigned SW  = ((CNT_WIDTH > PCW) ? CNT_WIDTH : PCW) + 1;
  localparam logic [SW-1:0] CNT_MAX = SW'({CNT_WIDTH{1'b1}});

  function automatic logic [PCW-1:0] popcount(input logic [CHANNELS-1:0] v);
    logic [PCW-1:0] n;
    n = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      n = n + PCW'(v[i]);
    end
    return n;
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] c,
                                                   input logic [PCW-1:0]       inc);
    logic [SW-1:0]        s;
    logic [CNT_WIDTH-1:0] r;
    s = SW'(c) + SW'(inc);
    if (s > CNT_MAX) begin
      r = '1;
    end else begin
      r = s[CNT_WIDTH-1:0];
    end
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eq_count <= '0;
      lt_count <= '0;
      gt_count <= '0;
    end else if (stats_clr) begin
      eq_count <= '0;
      lt_count <= '0;
      gt_count <= '0;
    end else if (transfer) begin
      eq_count <= sat_add(eq_count, popcount(eq_d));
      lt_count <= sat_add(lt_count, popcount(lt_d));
      gt_count <= sat_add(gt_count, popcount(gt_d));
    end
  end
`else
  logic                stats_clr_unused;
  localparam int unsigned CNT_WIDTH_UNUSED = CNT_WIDTH;
  assign stats_clr_unused = stats_clr;
`endif

endmodule

// File: doc/cmp_array.md
CMP_ARRAY -- requirements
Module: cmp_array

Interface
REQ-001 The block SHALL have parameter WIDTH, default DATA_WIDTH (soc_pkg), meaning operand width in bits, legal range 2..64.
REQ-002 The block SHALL have parameter CHANNELS, default 4, meaning number of independent compare lanes, legal range 1..16.
REQ-003 The block SHALL have parameter CNT_WIDTH, default 16, meaning width of each statistics counter.
REQ-004 The block SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1, meaning reset, asynchronous and active-low.
REQ-006 The block SHALL have port in_valid, input, 1, meaning the operand set is valid.
REQ-007 The block SHALL have port in_ready, output, 1, meaning the block accepts the operand set this cycle.
REQ-008 The block SHALL have port signed_mode, input, 1, meaning 1 compares operands as two's complement and 0 compares them as unsigned; sampled with the operands.
REQ-009 The block SHALL have port a, input, CHANNELS*WIDTH, meaning packed lane operands, lane i at bits [i*WIDTH +: WIDTH].
REQ-010 The block SHALL have port b, input, CHANNELS*WIDTH, meaning packed lane operands, same packing as a.
REQ-011 The block SHALL have port out_valid, output, 1, meaning the result registers hold an unconsumed result.
REQ-012 The block SHALL have port out_ready, input, 1, meaning the consumer accepts the result.
REQ-013 The block SHALL have ports equal, less and greater, output, CHANNELS each, meaning per-lane a==b, a<b and a>b.
REQ-014 The block SHALL have port all_equal, output, 1, meaning AND of all equal bits.
REQ-015 The block SHALL have port stats_clr, input, 1, meaning synchronous clear of the statistics counters.
REQ-016 The block SHALL have ports eq_count, lt_count and gt_count, output, CNT_WIDTH each, meaning the statistics counters; present only when CMP_ARRAY_STATS_EN is defined.

Function
REQ-017 in_ready SHALL equal (!out_valid || out_ready), combinationally.
REQ-018 A transfer SHALL occur when in_valid && in_ready; on that edge, all result registers load the comparison of the presented a, b and signed_mode, and out_valid sets to 1.
REQ-019 Latency SHALL be exactly one cycle from input transfer to out_valid=1.
REQ-020 When out_valid && out_ready && !in_valid, out_valid SHALL clear to 0 and the result registers SHALL hold their values.
REQ-021 When out_valid && out_ready && in_valid, the new result SHALL load, out_valid SHALL stay 1, and full throughput of one result per cycle SHALL be sustained.
REQ-022 When out_valid && !out_ready, the result registers SHALL remain stable and in_ready SHALL be 0.
REQ-023 Per lane, exactly one of equal, less or greater SHALL be 1 whenever out_valid=1.
REQ-024 In signed mode, the most negative value (MSB=1, others 0) SHALL compare less than every other value; in unsigned mode, the all-ones value SHALL compare greater than every other value.

Reset
REQ-025 Assertion of rst_n=0 SHALL asynchronously force out_valid=0, equal/less/greater=0, all_equal=0 and all counters to 0, including when asserted mid-transfer or while stalled.
REQ-026 After deassertion, the first transfer SHALL be accepted on the first rising edge with in_valid=1.

Configuration
REQ-027 With CMP_ARRAY_STATS_EN defined, the counters on each input transfer SHALL add the popcount of the newly loaded equal, less and greater vectors respectively, saturating at all-ones without wrap.
REQ-028 With CMP_ARRAY_STATS_EN defined, stats_clr SHALL zero the counters and take priority over a simultaneous increment.
REQ-029 Without CMP_ARRAY_STATS_EN, no count ports or counter logic SHALL exist, and stats_clr SHALL be ignored.

Verification
REQ-030 The bench SHALL cover: WIDTH=8, CHANNELS=4, unsigned, a={8'h00,8'h7F,8'hFF,8'h10}, b={8'h00,8'h80,8'h01,8'h10} -> one cycle later out_valid=1, equal=4'b1001, less=4'b0100, greater=4'b0010, all_equal=0.
REQ-031 The bench SHALL cover: the same operands with signed_mode=1 -> less=4'b0010, greater=4'b0100, equal=4'b1001.
REQ-032 The bench SHALL cover: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and outputs stable; out_ready=1 with back-to-back inputs -> one result per cycle, none lost or duplicated.
REQ-033 The bench SHALL cover: rst_n=0 while out_valid=1 and stalled -> out_valid=0 and all flags 0 immediately, without waiting for a clock edge.
REQ-034 The bench SHALL cover, with the macro and CNT_WIDTH=4: 5 transfers with a==b on 4 lanes -> eq_count holds at 4'hF with no wrap; stats_clr with a simultaneous transfer -> eq_count=0.
REQ-035 The bench SHALL cover: 1000 random transfers with random out_ready, checked against a behavioural reference model in both modes -> zero mismatches.
